// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: moves words from a FIFO to a UART transmitter one at a time. It either streams
// words as they arrive or sends them in fixed-length bursts, with an idle timeout that flushes a partial burst.
module fifo_rd_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned CNT_W     = 9,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned TIMEOUT   = 50000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              mode,
   input  logic              fifo_empty,
   input  logic [CNT_W-1:0]  fifo_rd_cnt,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   input  logic              tx_busy,
   output logic              tx_en,
   output logic [DATA_W-1:0] tx_data,
   output logic              rd_active,
   output logic [15:0]       sent_cnt
);

   localparam int unsigned      TO_W      = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StLatch,
      StSend,
      StWaitAck,
      StWaitDone
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [15:0]       sent_cnt_q, sent_cnt_d;
   logic [CNT_W-1:0]  burst_rem_q, burst_rem_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   // Mode sampled when leaving IDLE, so a running word or burst finishes under its own mode.
   logic              burst_q, burst_d;
   logic              below_burst;
   logic              to_run;
   logic              to_hit;

   assign below_burst = (fifo_rd_cnt < BURST_CNT);
   assign to_run      = (state_q == StIdle) && mode && !fifo_empty && below_burst;
   assign to_hit      = to_run && (to_cnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      sent_cnt_d  = sent_cnt_q;
      burst_rem_d = burst_rem_q;
      burst_d     = burst_q;
      to_cnt_d    = (to_run && !to_hit) ? to_cnt_q + 1'b1 : '0;
      fifo_rd_en  = 1'b0;
      tx_en       = 1'b0;

      case (state_q)
         StIdle: begin
            if (mode) begin
               if (!fifo_empty && (!below_burst || to_hit)) begin
                  state_d     = StRead;
                  burst_rem_d = BURST_CNT;
                  burst_d     = 1'b1;
               end
            end else if (!fifo_empty) begin
               state_d = StRead;
               burst_d = 1'b0;
            end
         end
         StRead: begin
            if (fifo_empty) begin
               state_d = StIdle;
            end else begin
               fifo_rd_en = 1'b1;
               state_d    = StLatch;
            end
         end
         StLatch: begin
            tx_data_d = fifo_dout;
            state_d   = StSend;
         end
         StSend: begin
            if (!tx_busy) begin
               tx_en      = 1'b1;
               sent_cnt_d = sent_cnt_q + 16'd1;
               state_d    = StWaitAck;
            end
         end
         StWaitAck: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               if (burst_q) begin
                  if (burst_rem_q != '0) begin
                     burst_rem_d = burst_rem_q - 1'b1;
                  end
                  state_d = ((burst_rem_d != '0) && !fifo_empty) ? StRead : StIdle;
               end else begin
                  state_d = fifo_empty ? StIdle : StRead;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= StIdle;
         tx_data_q   <= '0;
         sent_cnt_q  <= '0;
         burst_rem_q <= '0;
         to_cnt_q    <= '0;
         burst_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         sent_cnt_q  <= sent_cnt_d;
         burst_rem_q <= burst_rem_d;
         to_cnt_q    <= to_cnt_d;
         burst_q     <= burst_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign sent_cnt  = sent_cnt_q;
   assign rd_active = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized bench with behavioural FIFO and UART models, a word-order
// scoreboard and burst/timeout expectations derived from fill levels.
module tb_fifo_rd_ctrl;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 9;
   localparam int BL     = 4;
   localparam int TO     = 100;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic              mode;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_rd_cnt;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_rd_en;
   logic              tx_busy;
   logic              tx_en;
   logic [DATA_W-1:0] tx_data;
   logic              rd_active;
   logic [15:0]       sent_cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0]  fifo_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  pend_q[$];
   logic [15:0] sent_model;
   int          pops, sends, tx_seen, idle_carry;
   bit          s_rd_en, s_tx_en;
   bit          uart_busy, busy_hold, busy_hold_req;
   int unsigned uart_left, busy_min, busy_max;

   fifo_rd_ctrl #(
      .DATA_W   (DATA_W),
      .CNT_W    (CNT_W),
      .BURST_LEN(BL),
      .TIMEOUT  (TO)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .mode       (mode),
      .fifo_empty (fifo_empty),
      .fifo_rd_cnt(fifo_rd_cnt),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .tx_busy    (tx_busy),
      .tx_en      (tx_en),
      .tx_data    (tx_data),
      .rd_active  (rd_active),
      .sent_cnt   (sent_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void sync_flags();
      fifo_empty  = (fifo_q.size() == 0);
      fifo_rd_cnt = CNT_W'(fifo_q.size());
      tx_busy     = uart_busy | busy_hold;
   endfunction

   task automatic push(input logic [7:0] b);
      pend_q.push_back(b);
   endtask

   // Models change inputs 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      if (s_rd_en && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
      while (pend_q.size() != 0) begin
         logic [7:0] b;
         b = pend_q.pop_front();
         fifo_q.push_back(b);
         exp_q.push_back(b);
      end
      if (uart_left > 0) begin
         uart_left--;
         if (uart_left == 0) uart_busy = 1'b0;
      end
      if (s_tx_en) begin
         uart_busy = 1'b1;
         uart_left = $urandom_range(busy_max, busy_min);
      end
      busy_hold = busy_hold_req;
      sync_flags();
      @(negedge sys_clk);
      s_rd_en = fifo_rd_en;
      s_tx_en = tx_en;
      total++;
      if (sent_cnt !== sent_model)
         begin bad++; $display("FAIL sent_cnt: got %0d want %0d", sent_cnt, sent_model); end
      if (fifo_rd_en) begin
         pops++;
         total++;
         if (fifo_q.size() == 0) begin bad++; $display("FAIL rd_en_while_empty: got 1 want 0"); end
         total++;
         if (pops - sends > 1)
            begin bad++; $display("FAIL outstanding: got %0d want <=1", pops - sends); end
      end
      if (tx_en) begin
         total++;
         if (tx_busy) begin bad++; $display("FAIL tx_en_while_busy: got 1 want 0"); end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL tx_extra: got word %h want none", tx_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (tx_data !== e) begin bad++; $display("FAIL tx_data: got %h want %h", tx_data, e); end
         end
         sent_model++;
         sends++;
         tx_seen++;
      end
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      tick();
      while ((rd_active || fifo_q.size() != 0 || pend_q.size() != 0 || uart_busy) && n < bound) begin
         tick();
         n++;
      end
      total++;
      if (n >= bound) begin bad++; $display("FAIL %s: got still busy want idle within %0d", name, bound); end
   endtask

   // Observes one burst: qualifying idle cycles (IDLE with data present) before READ, fill at READ, words sent.
   task automatic wait_burst(input int bound, output int words, output int idle_wait,
                             output int start_fill, output bit ok);
      int n = 0;
      int w0;
      idle_wait  = idle_carry;
      words      = 0;
      start_fill = 0;
      ok         = 1'b0;
      while (n < bound) begin
         tick();
         n++;
         if (rd_active) break;
         if (fifo_q.size() != 0) idle_wait++;
      end
      if (!rd_active) return;
      start_fill = fifo_q.size();
      w0 = tx_seen;
      while (rd_active && n < bound) begin
         tick();
         n++;
      end
      if (rd_active) return;
      words      = tx_seen - w0;
      idle_carry = (fifo_q.size() != 0) ? 1 : 0;
      ok         = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge sys_clk);
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      total++; if (rd_active !== 1'b0) begin bad++; $display("FAIL reset_rd_active: got %b want 0", rd_active); end
      total++; if (sent_cnt !== 16'd0) begin bad++; $display("FAIL reset_sent_cnt: got %0d want 0", sent_cnt); end
      sys_rst_n = 1'b1;
      repeat (5) tick();
      total++; if (rd_active !== 1'b0) begin bad++; $display("FAIL empty_idle: got %b want 0", rd_active); end
   endtask

   task automatic test_stream();
      mode = 1'b0; busy_min = 10; busy_max = 10; tx_seen = 0;
      push(8'hA5);
      push(8'h3C);
      wait_idle(300, "stream_drain");
      total++; if (tx_seen != 2) begin bad++; $display("FAIL stream_words: got %0d want 2", tx_seen); end
      total++; if (sent_cnt !== 16'd2) begin bad++; $display("FAIL stream_sent_cnt: got %0d want 2", sent_cnt); end
      total++; if (rd_active !== 1'b0) begin bad++; $display("FAIL stream_idle: got %b want 0", rd_active); end
   endtask

   task automatic test_busy_stall();
      mode = 1'b0; busy_min = 2; busy_max = 2; tx_seen = 0;
      busy_hold_req = 1'b1;
      push(8'h5A);
      repeat (20) tick();
      total++; if (tx_seen != 0) begin bad++; $display("FAIL stall_tx_en: got %0d want 0", tx_seen); end
      total++; if (rd_active !== 1'b1) begin bad++; $display("FAIL stall_active: got %b want 1", rd_active); end
      busy_hold_req = 1'b0;
      wait_idle(100, "stall_drain");
      total++; if (tx_seen != 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", tx_seen); end
   endtask

   task automatic test_stream_random();
      int n_push = 0;
      mode = 1'b0; busy_min = 1; busy_max = 6; tx_seen = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(3, 0) == 0) begin
            push(8'($urandom));
            n_push++;
         end
         tick();
      end
      wait_idle(3000, "random_drain");
      total++; if (tx_seen != n_push) begin bad++; $display("FAIL random_words: got %0d want %0d", tx_seen, n_push); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_unsent: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_burst_threshold();
      int w, iw, sf, p0;
      bit ok;
      mode = 1'b1; busy_min = 2; busy_max = 4; tx_seen = 0; idle_carry = 0;
      repeat (3) push(8'($urandom));
      p0 = pops;
      repeat (50) tick();
      total++; if (pops != p0) begin bad++; $display("FAIL below_threshold_reads: got %0d want 0", pops - p0); end
      repeat (3) push(8'($urandom));
      wait_burst(400, w, iw, sf, ok);
      total++; if (!ok) begin bad++; $display("FAIL thr_burst: got no burst want burst"); end
      total++; if (w != BL) begin bad++; $display("FAIL thr_words: got %0d want %0d", w, BL); end
      total++; if (fifo_q.size() != 2) begin bad++; $display("FAIL thr_fill_left: got %0d want 2", fifo_q.size()); end
      total++; if (iw != 1) begin bad++; $display("FAIL thr_latency: got %0d want 1", iw); end
      wait_burst(400, w, iw, sf, ok);
      total++; if (!ok || w != 2) begin bad++; $display("FAIL thr_tail_words: got %0d want 2", w); end
      total++; if (iw != TO) begin bad++; $display("FAIL thr_tail_timeout: got %0d want %0d", iw, TO); end
   endtask

   task automatic test_timeout_flush();
      int w, iw, sf;
      bit ok;
      mode = 1'b1; busy_min = 1; busy_max = 3; idle_carry = 0;
      push(8'h11);
      push(8'h22);
      wait_burst(400, w, iw, sf, ok);
      total++; if (!ok) begin bad++; $display("FAIL to_burst: got no burst want burst"); end
      total++; if (iw != TO) begin bad++; $display("FAIL to_cycles: got %0d want %0d", iw, TO); end
      total++; if (w != 2) begin bad++; $display("FAIL to_words: got %0d want 2", w); end
      total++; if (rd_active !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", rd_active); end
   endtask

   task automatic test_burst_random();
      int w, iw, sf, k, left, exp_w;
      bit ok;
      mode = 1'b1; busy_min = 1; busy_max = 4;
      for (int it = 0; it < 5; it++) begin
         k = int'($urandom_range(11, 1));
         idle_carry = 0;
         repeat (k) push(8'($urandom));
         left = k;
         for (int b = 0; b < 12 && left > 0; b++) begin
            wait_burst(600, w, iw, sf, ok);
            exp_w = (sf < BL) ? sf : BL;
            total++;
            if (!ok || w != exp_w) begin bad++; $display("FAIL rb_words: got %0d want %0d", w, exp_w); end
            total++;
            if (iw != ((sf < BL) ? TO : 1))
               begin bad++; $display("FAIL rb_wait: got %0d want %0d", iw, (sf < BL) ? TO : 1); end
            if (w == 0) break;
            left -= w;
         end
      end
   endtask

   task automatic test_mode_switch();
      int n = 0;
      mode = 1'b1; busy_min = 2; busy_max = 2; tx_seen = 0;
      repeat (6) push(8'($urandom));
      while (tx_seen == 0 && n < 100) begin tick(); n++; end
      mode = 1'b0;
      while (rd_active && n < 300) begin tick(); n++; end
      total++; if (tx_seen != BL) begin bad++; $display("FAIL switch_old_burst: got %0d want %0d", tx_seen, BL); end
      wait_idle(200, "switch_drain");
      total++; if (tx_seen != 6) begin bad++; $display("FAIL switch_stream: got %0d want 6", tx_seen); end
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      mode = 1'b0; busy_min = 8; busy_max = 8; tx_seen = 0;
      push(8'h96);
      while (tx_seen == 0 && n < 50) begin tick(); n++; end
      total++; if (tx_seen != 1) begin bad++; $display("FAIL mid_first_send: got %0d want 1", tx_seen); end
      repeat (3) tick();
      total++; if (rd_active !== 1'b1) begin bad++; $display("FAIL mid_active: got %b want 1", rd_active); end
      #2 sys_rst_n = 1'b0;
      #1;
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %b want 0", fifo_rd_en); end
      total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL mid_tx_en: got %b want 0", tx_en); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
      total++; if (rd_active !== 1'b0) begin bad++; $display("FAIL mid_rd_active: got %b want 0", rd_active); end
      total++; if (sent_cnt !== 16'd0) begin bad++; $display("FAIL mid_sent_cnt: got %0d want 0", sent_cnt); end
      sent_model = 16'd0; pops = 0; sends = 0; s_rd_en = 1'b0; s_tx_en = 1'b0;
      repeat (2) tick();
      sys_rst_n = 1'b1;
      tx_seen = 0;
      repeat (30) tick();
      total++; if (tx_seen != 0) begin bad++; $display("FAIL mid_post_tx: got %0d want 0", tx_seen); end
      total++; if (rd_active !== 1'b0) begin bad++; $display("FAIL mid_post_idle: got %b want 0", rd_active); end
      push(8'hC3);
      wait_idle(200, "mid_resume");
      total++; if (tx_seen != 1) begin bad++; $display("FAIL mid_resume_words: got %0d want 1", tx_seen); end
      total++; if (sent_cnt !== 16'd1) begin bad++; $display("FAIL mid_resume_cnt: got %0d want 1", sent_cnt); end
   endtask

   task automatic test_wrap();
      mode = 1'b0; busy_min = 1; busy_max = 2;
      sent_model = 16'hFFFF;
      force dut.sent_cnt_q = 16'hFFFF;
      repeat (2) tick();
      release dut.sent_cnt_q;
      repeat (2) tick();
      push(8'h7E);
      wait_idle(100, "wrap_drain");
      total++; if (sent_cnt !== 16'd0) begin bad++; $display("FAIL wrap: got %0d want 0", sent_cnt); end
   endtask

   initial begin
      sys_rst_n = 1'b0; mode = 1'b0; fifo_dout = '0;
      uart_busy = 1'b0; busy_hold = 1'b0; busy_hold_req = 1'b0; uart_left = 0;
      busy_min = 1; busy_max = 1; s_rd_en = 1'b0; s_tx_en = 1'b0;
      sent_model = 16'd0; pops = 0; sends = 0; tx_seen = 0; idle_carry = 0;
      sync_flags();
      test_reset();
      test_stream();
      test_busy_stall();
      test_stream_random();
      test_burst_threshold();
      test_timeout_flush();
      test_burst_random();
      test_mode_switch();
      test_reset_midframe();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
